axis_log_arbiter: RTL and testbench

- Merges the M_AXIS_LOG streams of up to 8 statistics collectors into one log stream for the shared log DMA/FIFO.
- Sits directly downstream of each eth_stats_collector instance.
- Arbitrates round-robin at message granularity; a message is all beats up to and including tlast, and is never interleaved with another.
- Tags each output beat with the source index and counts forwarded messages.

---
 rtl/log_pkg.sv | 31 +++
 rtl/axis_log_arbiter_if.sv | 31 +++
 rtl/axis_log_reg_slice.sv | 41 ++++
 rtl/axis_log_arbiter.sv | 110 +++++++++++
 tb/tb_axis_log_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/log_pkg.sv
// Shared definitions for the log-stream arbiter: default beat width,
// FSM state encoding and the round-robin pick function.
package log_pkg;

  localparam int LOG_WIDTH_DEFAULT = 64;
  localparam int LOG_MAX_INPUTS    = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // First set bit of valid_vec scanning last+1 .. last+num (mod num).
  // If nothing is valid, last is returned unchanged.
  function automatic logic [2:0] rr_next(input logic [7:0] valid_vec,
                                         input logic [2:0] last,
                                         input int         num);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= LOG_MAX_INPUTS; i++) begin
      idx = (int'(last) + i) % num;
      if (!found && (i <= num) && valid_vec[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_log_arbiter_if.sv
// Bundle of the per-source input streams and the merged output stream.
// slave is the arbiter's view, master the view of whatever drives it.
interface axis_log_arbiter_if
  import log_pkg::*;
#(
  parameter int C_NUM_INPUTS     = 4,
  parameter int C_AXIS_LOG_WIDTH = LOG_WIDTH_DEFAULT,
  parameter int C_DEST_WIDTH     = 3
);
  logic [C_NUM_INPUTS*C_AXIS_LOG_WIDTH-1:0] s_axis_log_tdata;
  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tlast;
  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tvalid;
  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tready;
  logic [C_AXIS_LOG_WIDTH-1:0]              m_axis_log_tdata;
  logic [C_DEST_WIDTH-1:0]                  m_axis_log_tdest;
  logic                                     m_axis_log_tlast;
  logic                                     m_axis_log_tvalid;
  logic                                     m_axis_log_tready;

  modport slave (
    input  s_axis_log_tdata, s_axis_log_tlast, s_axis_log_tvalid, m_axis_log_tready,
    output s_axis_log_tready, m_axis_log_tdata, m_axis_log_tdest, m_axis_log_tlast,
           m_axis_log_tvalid
  );

  modport master (
    output s_axis_log_tdata, s_axis_log_tlast, s_axis_log_tvalid, m_axis_log_tready,
    input  s_axis_log_tready, m_axis_log_tdata, m_axis_log_tdest, m_axis_log_tlast,
           m_axis_log_tvalid
  );
endinterface

// File: rtl/axis_log_reg_slice.sv
// Two-entry skid buffer. in_ready depends only on the registered skid
// flag, so there is no combinational path from out_ready back upstream.
module axis_log_reg_slice #(
  parameter int C_PAYLOAD_WIDTH = 68
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [C_PAYLOAD_WIDTH-1:0] in_payload,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [C_PAYLOAD_WIDTH-1:0] out_payload,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       skid_full
);
  logic [C_PAYLOAD_WIDTH-1:0] skid_payload;

  assign in_ready = ~skid_full;

  // Refill the output from skid first, else pass through; park in skid while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_payload  <= '0;
      out_valid    <= 1'b0;
      skid_payload <= '0;
      skid_full    <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_full) begin
        out_payload <= skid_payload;
        out_valid   <= 1'b1;
        skid_full   <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_payload <= in_payload;
      end
    end else if (in_valid && !skid_full) begin
      skid_payload <= in_payload;
      skid_full    <= 1'b1;
    end
  end
endmodule

// File: rtl/axis_log_arbiter.sv
// Round-robin merge of several log streams at message granularity.
//   state    | meaning
//   ST_IDLE  | no grant held; pick next source with valid (one cycle)
//   ST_GRANT | forward beats of grant until its tlast is accepted
module axis_log_arbiter
  import log_pkg::*;
#(
  parameter int C_NUM_INPUTS     = 4,
  parameter int C_AXIS_LOG_WIDTH = LOG_WIDTH_DEFAULT,
  parameter int C_DEST_WIDTH     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  axis_log_arbiter_if.slave       log_bus,
  output logic [31:0]             msg_count,
  output logic                    busy
);
  localparam int PW = C_AXIS_LOG_WIDTH + C_DEST_WIDTH + 1;

  logic [0:0]                  state;
  logic [2:0]                  grant;
  logic [2:0]                  last_grant;
  logic [C_AXIS_LOG_WIDTH-1:0] sel_data;
  logic                        sel_last;
  logic                        sel_valid;
  logic                        in_valid;
  logic                        slice_ready;
  logic                        skid_full;
  logic                        accept;
  logic [PW-1:0]               out_payload;
  logic [31:0]                 msg_count_q;

  // Grant mux: steer the granted source onto the slice input.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < C_NUM_INPUTS; i++) begin
      if (grant == 3'(i)) begin
        sel_data  = log_bus.s_axis_log_tdata[i*C_AXIS_LOG_WIDTH +: C_AXIS_LOG_WIDTH];
        sel_last  = log_bus.s_axis_log_tlast[i];
        sel_valid = log_bus.s_axis_log_tvalid[i];
      end
    end
  end

  // Only the granted source sees ready, and only while the slice has room.
  always_comb begin
    log_bus.s_axis_log_tready = '0;
    for (int i = 0; i < C_NUM_INPUTS; i++) begin
      log_bus.s_axis_log_tready[i] = (state == ST_GRANT) && (grant == 3'(i)) && slice_ready;
    end
  end

  assign in_valid = (state == ST_GRANT) && sel_valid;
  assign accept   = in_valid && slice_ready;

  // Arbitration FSM; a stalled granted source keeps the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= 3'(C_NUM_INPUTS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|log_bus.s_axis_log_tvalid) begin
            grant <= rr_next(8'(log_bus.s_axis_log_tvalid), last_grant, C_NUM_INPUTS);
            state <= ST_GRANT;
          end
        end
        default: begin
          if (accept && sel_last) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  axis_log_reg_slice #(.C_PAYLOAD_WIDTH(PW)) u_slice (
    .clk         (clk),
    .rst         (rst),
    .in_payload  ({sel_data, C_DEST_WIDTH'(grant), sel_last}),
    .in_valid    (in_valid),
    .in_ready    (slice_ready),
    .out_payload (out_payload),
    .out_valid   (log_bus.m_axis_log_tvalid),
    .out_ready   (log_bus.m_axis_log_tready),
    .skid_full   (skid_full)
  );

  assign log_bus.m_axis_log_tdata = out_payload[PW-1 -: C_AXIS_LOG_WIDTH];
  assign log_bus.m_axis_log_tdest = out_payload[C_DEST_WIDTH:1];
  assign log_bus.m_axis_log_tlast = out_payload[0];

  // Count completed messages on the output side; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      msg_count_q <= '0;
    end else if (log_bus.m_axis_log_tvalid && log_bus.m_axis_log_tready &&
                 log_bus.m_axis_log_tlast) begin
      msg_count_q <= msg_count_q + 32'd1;
    end
  end

  assign msg_count = msg_count_q;
  assign busy      = (state == ST_GRANT) | log_bus.m_axis_log_tvalid | skid_full;
endmodule

// File: tb/tb_axis_log_arbiter.sv
// Bench for axis_log_arbiter: per-source beat queues drive the inputs,
// an expected-beat queue is compared against every output handshake.
module tb_axis_log_arbiter;
  import log_pkg::*;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int DW = 3;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } src_beat_t;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [DW-1:0] dest;
    logic          last;
  } out_beat_t;

  typedef struct {
    int            src;
    logic [W-1:0]  data;
    int            rdy;
    logic [DW-1:0] exp_dest;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] msg_count;
  logic        busy;

  axis_log_arbiter_if #(.C_NUM_INPUTS(N), .C_AXIS_LOG_WIDTH(W), .C_DEST_WIDTH(DW)) bus ();

  axis_log_arbiter #(.C_NUM_INPUTS(N), .C_AXIS_LOG_WIDTH(W), .C_DEST_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .log_bus   (bus.slave),
    .msg_count (msg_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  src_beat_t src_q [N][$];
  out_beat_t exp_q [$];
  int        hs_cyc [$];
  logic [N-1:0] src_gate = '0;
  int        rdy_mode = 0;
  int        cyc = 0;
  int        checks = 0;
  int        failures = 0;
  logic [N-1:0] hs_in;
  logic      prev_stall = 1'b0;
  out_beat_t prev_out;
  out_beat_t cur;
  out_beat_t exp_b;
  src_beat_t drop_b;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_src(input int i, input logic [W-1:0] d, input logic l);
    src_beat_t b;
    b.data = d;
    b.last = l;
    src_q[i].push_back(b);
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic [DW-1:0] dest, input logic l);
    out_beat_t b;
    b.data = d;
    b.dest = dest;
    b.last = l;
    exp_q.push_back(b);
  endtask

  function automatic bit src_pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_pending()) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || src_pending()) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d_beats_left required=0", name, exp_q.size());
    end
    repeat (2) begin @(negedge clk); #1; end
  endtask

  task automatic wait_hs(input string name, input int target, input int budget);
    int n = 0;
    while (hs_cyc.size() < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (hs_cyc.size() < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, hs_cyc.size(), target);
    end
  endtask

  // Monitor at negedge, then source/ready driver just after posedge.
  always begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
      hs_in      = '0;
    end else begin
      hs_in     = bus.s_axis_log_tvalid & bus.s_axis_log_tready;
      cur.data  = bus.m_axis_log_tdata;
      cur.dest  = bus.m_axis_log_tdest;
      cur.last  = bus.m_axis_log_tlast;
      if (prev_stall)
        chk("hold_stable", {bus.m_axis_log_tvalid, cur}, {1'b1, prev_out});
      if (bus.m_axis_log_tvalid && bus.m_axis_log_tready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=dest%0d_data%0h required=no_beat", cur.dest, cur.data);
        end else begin
          exp_b = exp_q.pop_front();
          chk("out_beat", cur, exp_b);
        end
      end
      prev_stall = bus.m_axis_log_tvalid && !bus.m_axis_log_tready;
      prev_out   = cur;
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++)
      if (hs_in[i] && !rst && src_q[i].size() > 0) drop_b = src_q[i].pop_front();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        bus.s_axis_log_tvalid[i]         = src_gate[i];
        bus.s_axis_log_tdata[i*W +: W]   = src_q[i][0].data;
        bus.s_axis_log_tlast[i]          = src_q[i][0].last;
      end else begin
        bus.s_axis_log_tvalid[i]         = 1'b0;
        bus.s_axis_log_tdata[i*W +: W]   = '0;
        bus.s_axis_log_tlast[i]          = 1'b0;
      end
    end
    case (rdy_mode)
      1:       bus.m_axis_log_tready = ~bus.m_axis_log_tready;
      2:       bus.m_axis_log_tready = 1'b0;
      default: bus.m_axis_log_tready = 1'b1;
    endcase
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [4];
    int   rel;
    int   base;
    bit   stall_ok;

    bus.s_axis_log_tdata  = '0;
    bus.s_axis_log_tlast  = '0;
    bus.s_axis_log_tvalid = '0;
    bus.m_axis_log_tready = 1'b1;

    // Reset with all inputs valid, then release and time the first beat.
    for (int i = 0; i < N; i++) begin
      push_src(i, 64'h10 + 64'(i), 1'b1);
      push_exp(64'h10 + 64'(i), 3'(i), 1'b1);
    end
    src_gate = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset_state", {bus.s_axis_log_tready, bus.m_axis_log_tvalid, msg_count, busy}, '0);
    end
    #1;
    rst = 1'b0;
    rel = cyc;
    drain("reset_release", 100);
    if (hs_cyc.size() > 0) chk("first_beat_latency", 128'(hs_cyc[0] - rel), 128'd2);
    else chk("first_beat_seen", 128'(hs_cyc.size()), 128'd4);
    chk("reset_release_count", msg_count, 32'd4);

    // Round robin, two-beat messages from every input at once.
    hs_cyc.delete();
    base = int'(msg_count);
    for (int i = 0; i < N; i++) begin
      push_src(i, 64'hA0 + 64'(i), 1'b0);
      push_src(i, 64'hB0 + 64'(i), 1'b1);
      push_exp(64'hA0 + 64'(i), 3'(i), 1'b0);
      push_exp(64'hB0 + 64'(i), 3'(i), 1'b1);
    end
    drain("rr", 200);
    chk("rr_msg_count", msg_count, 32'(base + 4));
    chk("rr_beats", 128'(hs_cyc.size()), 128'd8);
    if (hs_cyc.size() == 8) begin
      for (int k = 0; k < 4; k++) chk("rr_in_msg_gap", 128'(hs_cyc[2*k+1] - hs_cyc[2*k]), 128'd1);
      for (int k = 0; k < 3; k++) chk("rr_msg_gap", 128'(hs_cyc[2*k+2] - hs_cyc[2*k+1]), 128'd2);
    end

    // Table of single-beat messages with varied ready behaviour.
    vecs[0] = '{2, 64'hDEAD_BEEF_0123_4567, 0, 3'd2};
    vecs[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3'd0};
    vecs[2] = '{3, 64'h0000_0000_0000_0000, 0, 3'd3};
    vecs[3] = '{1, 64'h5555_AAAA_5555_AAAA, 1, 3'd1};
    for (int v = 0; v < 4; v++) begin
      base     = int'(msg_count);
      rdy_mode = vecs[v].rdy;
      push_src(vecs[v].src, vecs[v].data, 1'b1);
      push_exp(vecs[v].data, vecs[v].exp_dest, 1'b1);
      drain("vec", 100);
      chk("vec_msg_count", msg_count, 32'(base + 1));
      chk("vec_busy_idle", 128'(busy), 128'd0);
    end
    rdy_mode = 0;

    // Fairness: input 2 arrives while input 1 is streaming.
    hs_cyc.delete();
    src_gate = 4'b0010;
    for (int m = 0; m < 3; m++)
      for (int b = 0; b < 3; b++) push_src(1, 64'h100 + 64'(m*16 + b), b == 2);
    push_src(2, 64'h200, 1'b1);
    for (int b = 0; b < 3; b++) push_exp(64'h100 + 64'(b), 3'd1, b == 2);
    push_exp(64'h200, 3'd2, 1'b1);
    for (int m = 1; m < 3; m++)
      for (int b = 0; b < 3; b++) push_exp(64'h100 + 64'(m*16 + b), 3'd1, b == 2);
    wait_hs("fair_first", 1, 50);
    src_gate = '1;
    drain("fair", 300);

    // Backpressure: ready toggles during a five-beat message from input 3.
    hs_cyc.delete();
    rdy_mode = 1;
    for (int b = 1; b <= 5; b++) begin
      push_src(3, 64'(b), b == 5);
      push_exp(64'(b), 3'd3, b == 5);
    end
    drain("bp", 200);
    rdy_mode = 0;
    chk("bp_beats", 128'(hs_cyc.size()), 128'd5);

    // Counter wrap, using input 3 so the grant history is unchanged.
    @(negedge clk); #1;
    force dut.msg_count_q = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    release dut.msg_count_q;
    chk("wrap_preset", msg_count, 32'hFFFF_FFFF);
    push_src(3, 64'h77, 1'b1);
    push_exp(64'h77, 3'd3, 1'b1);
    drain("wrap", 100);
    chk("wrap_count", msg_count, 32'd0);

    // Stalled source: granted input 0 drops valid while input 1 waits.
    hs_cyc.delete();
    for (int b = 0; b < 4; b++) begin
      push_src(0, 64'h300 + 64'(b), b == 3);
      push_exp(64'h300 + 64'(b), 3'd0, b == 3);
    end
    push_src(1, 64'h400, 1'b1);
    push_exp(64'h400, 3'd1, 1'b1);
    wait_hs("stall_first", 1, 50);
    src_gate[0] = 1'b0;
    stall_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.s_axis_log_tready[1] || !busy) stall_ok = 1'b0;
    end
    #1;
    chk("stall_tready1_low_busy", 128'(stall_ok), 128'd1);
    chk("stall_no_output", 128'(hs_cyc.size()), 128'd2);
    src_gate[0] = 1'b1;
    drain("stall", 200);

    // One message from input 0 so input 1 would win without reset.
    push_src(0, 64'h450, 1'b1);
    push_exp(64'h450, 3'd0, 1'b1);
    drain("pre_reset", 100);

    // Reset mid-message with the output stalled holding two beats.
    rdy_mode = 2;
    for (int b = 0; b < 4; b++) push_src(1, 64'h500 + 64'(b), b == 3);
    repeat (8) begin @(negedge clk); #1; end
    chk("pre_reset_hold", {bus.m_axis_log_tvalid, busy, bus.s_axis_log_tready}, {1'b1, 1'b1, 4'b0000});
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    rdy_mode = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("mid_reset_state", {bus.s_axis_log_tready, bus.m_axis_log_tvalid, msg_count, busy}, '0);
    end
    #1;
    rst = 1'b0;
    exp_q.delete();
    hs_cyc.delete();
    push_src(1, 64'h600, 1'b1);
    push_src(0, 64'h601, 1'b1);
    push_exp(64'h601, 3'd0, 1'b1);
    push_exp(64'h600, 3'd1, 1'b1);
    drain("post_reset", 100);
    chk("post_reset_count", msg_count, 32'd2);
    chk("post_reset_busy", 128'(busy), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
